// File: rtl/sram_write_drain_pkg.sv
// Shared types and helpers for the SRAM write-drain initiator.
package sram_write_drain_pkg;

  localparam int unsigned NUM_WR_PORTS  = 4;
  localparam int unsigned NUM_REQ_LANES = 4;
  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned DATA_W        = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/sram_write_drain_match.sv
// Youngest-match selector: among valid entries whose key equals the probe, the highest index wins.
module sram_write_drain_match #(
  parameter int unsigned NUM   = 4,
  parameter int unsigned KEY_W = 4,
  parameter int unsigned DAT_W = 8
) (
  input  logic [NUM-1:0]       valid,
  input  logic [NUM*KEY_W-1:0] keys,
  input  logic [NUM*DAT_W-1:0] datas,
  input  logic [KEY_W-1:0]     key,
  output logic                 hit,
  output logic [DAT_W-1:0]     data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < NUM; i++) begin
      if (valid[i] && (keys[i*KEY_W +: KEY_W] == key)) begin
        hit  = 1'b1;
        data = datas[i*DAT_W +: DAT_W];
      end
    end
  end

endmodule

// File: rtl/sram_write_drain.sv
// Write-side initiator for the multi-ported SRAM: in-order write queue, 4-wide drain onto
// registered write ports, and a bypass lookup over queued and in-flight writes.
module sram_write_drain
  import sram_write_drain_pkg::*;
#(
  parameter int unsigned SRAM_DEPTH = 16,
  parameter int unsigned SRAM_INDEX = ADDR_W,
  parameter int unsigned SRAM_WIDTH = DATA_W,
  parameter int unsigned QDEPTH     = 8,
  parameter int unsigned QINDEX     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              req_valid_i,
  input  logic [4*SRAM_INDEX-1:0] req_addr_i,
  input  logic [4*SRAM_WIDTH-1:0] req_data_i,
  output logic                    req_ready_o,
  input  logic [SRAM_INDEX-1:0]   lkp_addr_i,
  output logic                    lkp_hit_o,
  output logic [SRAM_WIDTH-1:0]   lkp_data_o,
  output logic                    we0_o,
  output logic                    we1_o,
  output logic                    we2_o,
  output logic                    we3_o,
  output logic [SRAM_INDEX-1:0]   addr0wr_o,
  output logic [SRAM_INDEX-1:0]   addr1wr_o,
  output logic [SRAM_INDEX-1:0]   addr2wr_o,
  output logic [SRAM_INDEX-1:0]   addr3wr_o,
  output logic [SRAM_WIDTH-1:0]   data0wr_o,
  output logic [SRAM_WIDTH-1:0]   data1wr_o,
  output logic [SRAM_WIDTH-1:0]   data2wr_o,
  output logic [SRAM_WIDTH-1:0]   data3wr_o,
  output logic [QINDEX:0]         count_o
);

  localparam int unsigned NumCand = NUM_WR_PORTS + QDEPTH;

  wr_req_t                 mem_q   [QDEPTH];
  logic [QINDEX-1:0]       head_q, tail_q;
  logic [QINDEX:0]         count_q;
  logic [NUM_WR_PORTS-1:0] we_q;
  logic [SRAM_INDEX-1:0]   waddr_q [NUM_WR_PORTS];
  logic [SRAM_WIDTH-1:0]   wdata_q [NUM_WR_PORTS];

  logic [2:0]                         req_n, pop_n;
  logic                               accept;
  wr_req_t                            pop_ent   [NUM_WR_PORTS];
  logic [NUM_WR_PORTS*SRAM_INDEX-1:0] pop_addrs;
  logic [NUM_WR_PORTS-1:0]            dup_valid [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0]            dup_hit, dup_flag, dup;

  always_comb begin
    req_n  = popcount4(req_valid_i);
    pop_n  = (count_q >= (QINDEX+1)'(NUM_WR_PORTS)) ? 3'(NUM_WR_PORTS) : 3'(count_q);
    // Slots freed by this cycle's drain are immediately reusable.
    req_ready_o = (32'(QDEPTH) - 32'(count_q) + 32'(pop_n)) >= 32'(NUM_REQ_LANES);
    accept = req_ready_o && (req_valid_i != '0);
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      pop_ent[k] = mem_q[head_q + QINDEX'(k)];
      pop_addrs[k*SRAM_INDEX +: SRAM_INDEX] = pop_ent[k].addr;
      for (int m = 0; m < NUM_WR_PORTS; m++) begin
        dup_valid[k][m] = (m > k) && (3'(m) < pop_n);
      end
    end
  end

  // A popped write is dropped when a younger popped write targets the same address.
  for (genvar j = 0; j < NUM_WR_PORTS; j++) begin : g_dup
    sram_write_drain_match #(
      .NUM  (NUM_WR_PORTS),
      .KEY_W(SRAM_INDEX),
      .DAT_W(1)
    ) u_dup (
      .valid(dup_valid[j]),
      .keys (pop_addrs),
      .datas({NUM_WR_PORTS{1'b1}}),
      .key  (pop_ent[j].addr),
      .hit  (dup_hit[j]),
      .data (dup_flag[j])
    );
    assign dup[j] = dup_hit[j] & dup_flag[j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= '0;
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        waddr_q[k] <= '0;
        wdata_q[k] <= '0;
      end
    end else begin
      head_q  <= head_q + QINDEX'(pop_n);
      count_q <= count_q + (accept ? (QINDEX+1)'(req_n) : '0) - (QINDEX+1)'(pop_n);
      if (accept) tail_q <= tail_q + QINDEX'(req_n);
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        we_q[k] <= (3'(k) < pop_n) && !dup[k];
        if (3'(k) < pop_n) begin
          waddr_q[k] <= pop_ent[k].addr;
          wdata_q[k] <= pop_ent[k].data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_REQ_LANES; k++) begin
        if (3'(k) < req_n) begin
          mem_q[tail_q + QINDEX'(k)] <= '{addr: req_addr_i[k*SRAM_INDEX +: SRAM_INDEX],
                                          data: req_data_i[k*SRAM_WIDTH +: SRAM_WIDTH]};
        end
      end
    end
  end

  // Candidates ordered oldest to youngest: output stage by port, then queue by age.
  logic [NumCand-1:0]            cand_valid;
  logic [NumCand*SRAM_INDEX-1:0] cand_keys;
  logic [NumCand*SRAM_WIDTH-1:0] cand_datas;
  logic                          match_hit, lkp_in_range;
  logic [SRAM_WIDTH-1:0]         match_data;

  always_comb begin
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      cand_valid[k]                           = we_q[k];
      cand_keys[k*SRAM_INDEX +: SRAM_INDEX]   = waddr_q[k];
      cand_datas[k*SRAM_WIDTH +: SRAM_WIDTH]  = wdata_q[k];
    end
    for (int i = 0; i < QDEPTH; i++) begin
      cand_valid[NUM_WR_PORTS+i] = (QINDEX+1)'(i) < count_q;
      cand_keys[(NUM_WR_PORTS+i)*SRAM_INDEX +: SRAM_INDEX] =
        mem_q[head_q + QINDEX'(i)].addr;
      cand_datas[(NUM_WR_PORTS+i)*SRAM_WIDTH +: SRAM_WIDTH] =
        mem_q[head_q + QINDEX'(i)].data;
    end
  end

  sram_write_drain_match #(
    .NUM  (NumCand),
    .KEY_W(SRAM_INDEX),
    .DAT_W(SRAM_WIDTH)
  ) u_lkp (
    .valid(cand_valid),
    .keys (cand_keys),
    .datas(cand_datas),
    .key  (lkp_addr_i),
    .hit  (match_hit),
    .data (match_data)
  );

  assign lkp_in_range = 32'(lkp_addr_i) < SRAM_DEPTH;
  assign lkp_hit_o    = match_hit && lkp_in_range;
  assign lkp_data_o   = lkp_in_range ? match_data : '0;

  assign we0_o     = we_q[0];
  assign we1_o     = we_q[1];
  assign we2_o     = we_q[2];
  assign we3_o     = we_q[3];
  assign addr0wr_o = waddr_q[0];
  assign addr1wr_o = waddr_q[1];
  assign addr2wr_o = waddr_q[2];
  assign addr3wr_o = waddr_q[3];
  assign data0wr_o = wdata_q[0];
  assign data1wr_o = wdata_q[1];
  assign data2wr_o = wdata_q[2];
  assign data3wr_o = wdata_q[3];
  assign count_o   = count_q;

endmodule
